mips_bus_mem_ctrl: RTL and testbench
====================================

MIPS_BUS_MEM_CTRL -- requirements
Module: mips_bus_mem_ctrl

Interface
REQ-001 Parameter WAIT_STATES, default 1: extra stall cycles inserted before each RAM access (0..15).
REQ-002 Parameter PROG_BASE, default 32'hBFC0_0000: byte base of the program region.
REQ-003 Parameter REGION_WORDS, default 4096: 32-bit words per region; the stack region base is 0.
REQ-004 Port list (name  direction  width  meaning):
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  32  CPU byte address; bits [1:0] are ignored.
- read  in  1  CPU read request.
- write  in  1  CPU write request.
- writedata  in  32  CPU write data.
- byteenable  in  4  CPU byte lanes; bit n selects bits [8n+7:8n].
- waitrequest  out  1  stall to the CPU.
- readdata  out  32  read result to the CPU.
- stack_addr, prog_addr  out  12 each  RAM word addresses (address[13:2]).
- stack_read, stack_write, prog_read, prog_write  out  1 each  RAM strobes.
- ram_writedata  out  32  write data shared by both RAMs.
- stack_readdata, prog_readdata  in  32 each  RAM outputs, valid the cycle after the read strobe.
- err_count  out  8  count of bad requests.
- busy  out  1  FSM not in IDLE.

Function
REQ-005 The FSM states SHALL be IDLE, WAIT, ACCESS, CAPTURE, MERGE, DONE.
REQ-006 Region decode: stack if address < REGION_WORDS*4; program if PROG_BASE <= address < PROG_BASE + REGION_WORDS*4; anything else is unmapped.
REQ-007 waitrequest SHALL be combinational: 1 when (read|write) and state != DONE; 0 in DONE; 0 in IDLE with no request.
REQ-008 In IDLE with read|write, the block SHALL latch address, op, writedata and byteenable, then enter WAIT (WAIT_STATES>0) or ACCESS.
REQ-009 WAIT SHALL last exactly WAIT_STATES cycles, using a 4-bit down-counter, then go to ACCESS.
REQ-010 ACCESS, read or partial write (byteenable not 0000 or 1111): assert the selected region's *_read for one cycle, then go to CAPTURE.
REQ-011 ACCESS, full write (1111): assert *_write for one cycle with ram_writedata = writedata, then go to DONE.
REQ-012 ACCESS, byteenable 0000 write: no strobe, then go to DONE.
REQ-013 CAPTURE, read: register the RAM data into readdata, then go to DONE.
REQ-014 CAPTURE, partial write: merge the enabled lanes of writedata over the RAM data, then go to MERGE.
REQ-015 MERGE SHALL assert *_write for one cycle with the merged word, then go to DONE.
REQ-016 DONE SHALL last one cycle, then go to IDLE; readdata holds its value until the next read completes.
REQ-017 Latency from the request cycle to waitrequest low (W = WAIT_STATES):
- full or zero-byteenable write: W+2 cycles.
- read: W+3 cycles.
- partial write: W+4 cycles.
REQ-018 Unmapped address: no RAM strobe; readdata = 0 for a read; a write is dropped; err_count increments; the FSM goes WAIT/ACCESS -> DONE.
REQ-019 read and write asserted together: treated as unmapped (REQ-018).
REQ-020 err_count SHALL saturate at 8'hFF.
REQ-021 At most one RAM strobe SHALL be high in any cycle, and only for the decoded region.
REQ-022 Changes to the CPU inputs while the FSM is not in IDLE SHALL be ignored; the latched copies are used.
REQ-023 A request still asserted in DONE SHALL be treated as completed, not re-accepted; a new request is accepted from IDLE only.

Reset
REQ-024 While reset = 0, asynchronously: state = IDLE, WAIT counter = 0, readdata = 0, err_count = 0, all RAM strobes = 0, busy = 0, latched registers = 0.
REQ-025 Reset asserted mid-transaction SHALL abort it with no further RAM strobe; a MERGE write in progress is dropped.
REQ-026 After reset deasserts, the first request SHALL be accepted on the first rising edge that sees read|write.

Verification
REQ-027 W=1, read at 32'hBFC0_0010, prog RAM word 4 = 32'h2402_0005 -> prog_read for 1 cycle, prog_addr = 4, waitrequest low in cycle 4, readdata = 32'h2402_0005.
REQ-028 W=0, write 32'hDEAD_BEEF with byteenable 1111 at 32'h0000_0100 -> one stack_write, stack_addr = 64, completes in 2 cycles, no read strobe.
REQ-029 W=0, stack word 8 = 32'h1122_3344, write 32'hAABB_CCDD with byteenable 0101 at 32'h20 -> stack_read, then stack_write of 32'h11BB_33DD, completes in 4 cycles.
REQ-030 Read at 32'h8000_0000, then read and write asserted together -> no strobes, readdata = 0, err_count = 2; 300 further bad requests leave err_count = 8'hFF.
REQ-031 W=3, write with byteenable 0011, reset pulled low during WAIT -> no stack_write ever, outputs at reset values immediately, next read completes normally.
REQ-032 The CPU changes address in the cycle after acceptance -> the original address is used; waitrequest is never low outside DONE.

Source files
------------

// File: rtl/mips_bus_mem_ctrl_if.sv
// CPU-side bus of the MIPS memory controller: request, byte lanes, stall and read return.
interface mips_bus_mem_ctrl_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata
   );
endinterface

// File: rtl/mips_bus_mem_ctrl.sv
// Bridges a stalling MIPS CPU bus onto separate stack and program RAMs, with optional
// wait states, read-modify-write for partial stores and a saturating bad-request counter.
module mips_bus_mem_ctrl #(
   parameter int unsigned WAIT_STATES  = 1,
   parameter logic [31:0] PROG_BASE    = 32'hBFC0_0000,
   parameter int unsigned REGION_WORDS = 4096
) (
   input  logic               clk,
   input  logic               reset,
   mips_bus_mem_ctrl_if.slave bus,
   output logic [11:0]        stack_addr,
   output logic [11:0]        prog_addr,
   output logic               stack_read,
   output logic               stack_write,
   output logic               prog_read,
   output logic               prog_write,
   output logic [31:0]        ram_writedata,
   input  logic [31:0]        stack_readdata,
   input  logic [31:0]        prog_readdata,
   output logic [7:0]         err_count,
   output logic               busy
);

   localparam logic [32:0] REGION_BYTES = 33'(REGION_WORDS) << 2;
   localparam logic [32:0] PROG_LO      = {1'b0, PROG_BASE};
   localparam logic [32:0] PROG_HI      = PROG_LO + REGION_BYTES;
   localparam logic [3:0]  WAIT_INIT    = 4'(WAIT_STATES);

   typedef enum logic [2:0] {IDLE, WAIT, ACCESS, CAPTURE, MERGE, DONE} state_t;

   state_t      state;
   state_t      next_state;
   logic [3:0]  wait_cnt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic        op_read_q;
   logic        op_write_q;
   logic [31:0] merged_q;
   logic [31:0] readdata_q;
   logic [7:0]  err_q;

   logic        request;
   logic        in_stack;
   logic        in_prog;
   logic        bad_req;
   logic        full_write;
   logic        zero_write;
   logic        needs_read;
   logic        strobe_rd;
   logic        strobe_wr;
   logic [31:0] ram_rdata;
   logic [31:0] merge_word;

   assign request = bus.read | bus.write;

   // Decode always works from the latched request so the CPU may change its inputs mid-transfer.
   always_comb begin
      in_stack   = {1'b0, addr_q} < REGION_BYTES;
      in_prog    = ({1'b0, addr_q} >= PROG_LO) && ({1'b0, addr_q} < PROG_HI);
      bad_req    = (op_read_q & op_write_q) | ~(in_stack | in_prog);
      full_write = (be_q == 4'hF);
      zero_write = (be_q == 4'h0);
      needs_read = op_read_q | ~(full_write | zero_write);
      ram_rdata  = in_stack ? stack_readdata : prog_readdata;
      merge_word = ram_rdata;
      for (int i = 0; i < 4; i++) begin
         if (be_q[i]) begin
            merge_word[8*i +: 8] = wdata_q[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      strobe_rd  = 1'b0;
      strobe_wr  = 1'b0;
      case (state)
         IDLE: begin
            if (request) begin
               next_state = (WAIT_INIT != 4'd0) ? WAIT : ACCESS;
            end
         end
         WAIT: begin
            if (wait_cnt <= 4'd1) begin
               next_state = ACCESS;
            end
         end
         ACCESS: begin
            if (bad_req) begin
               next_state = DONE;
            end else if (needs_read) begin
               strobe_rd  = 1'b1;
               next_state = CAPTURE;
            end else begin
               strobe_wr  = full_write;
               next_state = DONE;
            end
         end
         CAPTURE: begin
            next_state = op_read_q ? DONE : MERGE;
         end
         MERGE: begin
            strobe_wr  = 1'b1;
            next_state = DONE;
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Request capture, wait countdown, error accounting and read/merge data registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt   <= 4'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         be_q       <= 4'd0;
         op_read_q  <= 1'b0;
         op_write_q <= 1'b0;
         merged_q   <= 32'd0;
         readdata_q <= 32'd0;
         err_q      <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (request) begin
                  addr_q     <= bus.address;
                  wdata_q    <= bus.writedata;
                  be_q       <= bus.byteenable;
                  op_read_q  <= bus.read;
                  op_write_q <= bus.write;
                  wait_cnt   <= WAIT_INIT;
               end
            end
            WAIT: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ACCESS: begin
               if (bad_req) begin
                  if (err_q != 8'hFF) begin
                     err_q <= err_q + 8'd1;
                  end
                  if (op_read_q) begin
                     readdata_q <= 32'd0;
                  end
               end
            end
            CAPTURE: begin
               if (op_read_q) begin
                  readdata_q <= ram_rdata;
               end else begin
                  merged_q <= merge_word;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign stack_read    = strobe_rd & in_stack;
   assign prog_read     = strobe_rd & in_prog;
   assign stack_write   = strobe_wr & in_stack;
   assign prog_write    = strobe_wr & in_prog;
   assign stack_addr    = addr_q[13:2];
   assign prog_addr     = addr_q[13:2];
   assign ram_writedata = (state == MERGE) ? merged_q : wdata_q;

   assign bus.waitrequest = request & (state != DONE);
   assign bus.readdata    = readdata_q;
   assign err_count       = err_q;
   assign busy            = (state != IDLE);

endmodule

// File: tb/tb_mips_bus_mem_ctrl.sv
// Randomized self-checking bench: behavioural RAM/region model predicts data, latency and strobes.
module tb_mips_bus_mem_ctrl;
   localparam int          W  = 1;
   localparam logic [31:0] PB = 32'hBFC0_0000;
   localparam int          RW = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] stack_addr;
   logic [11:0] prog_addr;
   logic        stack_read;
   logic        stack_write;
   logic        prog_read;
   logic        prog_write;
   logic [31:0] ram_writedata;
   logic [31:0] stack_readdata;
   logic [31:0] prog_readdata;
   logic [7:0]  err_count;
   logic        busy;

   mips_bus_mem_ctrl_if bus();

   mips_bus_mem_ctrl #(
      .WAIT_STATES (W),
      .PROG_BASE   (PB),
      .REGION_WORDS(RW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .stack_addr    (stack_addr),
      .prog_addr     (prog_addr),
      .stack_read    (stack_read),
      .stack_write   (stack_write),
      .prog_read     (prog_read),
      .prog_write    (prog_write),
      .ram_writedata (ram_writedata),
      .stack_readdata(stack_readdata),
      .prog_readdata (prog_readdata),
      .err_count     (err_count),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   function automatic logic [31:0] seed_word(input bit prog, input int idx);
      if (!prog && idx == 8) return 32'h1122_3344;
      if (prog && idx == 4)  return 32'h2402_0005;
      return 32'(idx) * 32'h9E37_79B1 + (prog ? 32'h1357_9BDF : 32'h2468_ACE0);
   endfunction

   // Synchronous RAMs: data appears the cycle after the read strobe.
   logic [31:0] stack_ram [0:RW-1];
   logic [31:0] prog_ram  [0:RW-1];
   logic [31:0] stack_q;
   logic [31:0] prog_q;
   logic        ram_loaded = 1'b0;

   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < RW; i++) begin
            stack_ram[i] <= seed_word(1'b0, i);
            prog_ram[i]  <= seed_word(1'b1, i);
         end
         ram_loaded <= 1'b1;
      end else begin
         if (stack_read)  stack_q <= stack_ram[stack_addr];
         if (stack_write) stack_ram[stack_addr] <= ram_writedata;
         if (prog_read)   prog_q <= prog_ram[prog_addr];
         if (prog_write)  prog_ram[prog_addr] <= ram_writedata;
      end
   end

   assign stack_readdata = stack_q;
   assign prog_readdata  = prog_q;

   int stack_rd_n = 0;
   int stack_wr_n = 0;
   int prog_rd_n  = 0;
   int prog_wr_n  = 0;
   int multi_n    = 0;

   always @(negedge clk) begin
      stack_rd_n <= stack_rd_n + int'(stack_read);
      stack_wr_n <= stack_wr_n + int'(stack_write);
      prog_rd_n  <= prog_rd_n + int'(prog_read);
      prog_wr_n  <= prog_wr_n + int'(prog_write);
      if (int'(stack_read) + int'(stack_write) + int'(prog_read) + int'(prog_write) > 1) begin
         multi_n <= multi_n + 1;
      end
   end

   logic [31:0] stack_ref [0:RW-1];
   logic [31:0] prog_ref  [0:RW-1];
   int          err_exp   = 0;
   logic [31:0] last_read = 32'd0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr,
                                input logic [31:0] wdata, input logic [3:0] be, input bit scramble);
      logic [63:0] a;
      int          region;
      int          idx;
      bit          bad;
      int          exp_lat;
      logic [31:0] exp_strobes;
      logic [31:0] word;
      int          sr0, sw0, pr0, pw0;
      int          edges;
      bit          done;

      a = {32'd0, addr};
      idx = 0;
      if (a < 64'(RW * 4)) begin
         region = 0;
         idx = int'(a >> 2);
      end else if (a >= {32'd0, PB} && a < {32'd0, PB} + 64'(RW * 4)) begin
         region = 1;
         idx = int'((a - {32'd0, PB}) >> 2);
      end else begin
         region = 2;
      end
      bad = (rd && wr) || region == 2;
      exp_strobes = 32'd0;
      word = (region == 1) ? prog_ref[idx] : stack_ref[idx];

      if (bad) begin
         exp_lat = W + 2;
         if (err_exp < 255) err_exp++;
         if (rd) last_read = 32'd0;
      end else if (rd) begin
         exp_lat = W + 3;
         last_read = word;
         exp_strobes = (region == 0) ? 32'h0100_0000 : 32'h0000_0100;
      end else if (be == 4'hF || be == 4'h0) begin
         exp_lat = W + 2;
         if (be == 4'hF) begin
            word = wdata;
            exp_strobes = (region == 0) ? 32'h0001_0000 : 32'h0000_0001;
         end
      end else begin
         exp_lat = W + 4;
         for (int b = 0; b < 4; b++) begin
            if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
         end
         exp_strobes = (region == 0) ? 32'h0101_0000 : 32'h0000_0101;
      end
      if (!bad && !rd) begin
         if (region == 0) stack_ref[idx] = word;
         else prog_ref[idx] = word;
      end

      sr0 = stack_rd_n; sw0 = stack_wr_n; pr0 = prog_rd_n; pw0 = prog_wr_n;
      @(negedge clk);
      bus.address    = addr;
      bus.read       = rd;
      bus.write      = wr;
      bus.writedata  = wdata;
      bus.byteenable = be;
      #1;
      checkOutput("waitreq_on_request", 32'(bus.waitrequest), 32'd1);
      edges = 0;
      done  = 1'b0;
      while (!done && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
         if (!bus.waitrequest) begin
            done = 1'b1;
         end else if (edges == 1 && scramble) begin
            bus.address    = $urandom;
            bus.writedata  = $urandom;
            bus.byteenable = 4'($urandom_range(0, 15));
         end
      end
      checkOutput("latency", 32'(edges), 32'(exp_lat));
      checkOutput("readdata", bus.readdata, last_read);
      checkOutput("err_count", 32'(err_count), 32'(err_exp));
      @(posedge clk);
      #1;
      bus.read  = 1'b0;
      bus.write = 1'b0;
      checkOutput("busy_after_done", 32'(busy), 32'd0);
      checkOutput("strobes", {8'(stack_rd_n - sr0), 8'(stack_wr_n - sw0),
                              8'(prog_rd_n - pr0), 8'(prog_wr_n - pw0)}, exp_strobes);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          sw0;
      logic [31:0] addr;
      int          kind;
      int          rsel;
      int          wsel;

      for (int i = 0; i < RW; i++) begin
         stack_ref[i] = seed_word(1'b0, i);
         prog_ref[i]  = seed_word(1'b1, i);
      end
      reset          = 1'b0;
      bus.address    = 32'd0;
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      bus.writedata  = 32'd0;
      bus.byteenable = 4'd0;

      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_waitreq", 32'(bus.waitrequest), 32'd0);
      checkOutput("reset_readdata", bus.readdata, 32'd0);
      checkOutput("reset_err", 32'(err_count), 32'd0);
      checkOutput("reset_strobes", 32'({stack_read, stack_write, prog_read, prog_write}), 32'd0);
      reset = 1'b1;

      applyStimulus(32'hBFC0_0010, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0);
      applyStimulus(32'h0000_0100, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0);
      applyStimulus(32'h0000_0103, 1'b1, 1'b0, 32'd0, 4'h0, 1'b0);
      applyStimulus(32'h0000_0020, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0);
      applyStimulus(32'h0000_0020, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0);
      applyStimulus(32'h0000_0030, 1'b0, 1'b1, 32'h1234_5678, 4'h0, 1'b0);

      applyStimulus(32'h8000_0000, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0);
      applyStimulus(32'h0000_0040, 1'b1, 1'b1, 32'h0BAD_0BAD, 4'hF, 1'b0);
      checkOutput("err_two", 32'(err_count), 32'd2);
      for (int n = 0; n < 300; n++) begin
         applyStimulus(32'h8000_0000 + 32'(n * 4), n[0], 1'b1, $urandom, 4'hF, 1'b0);
      end
      checkOutput("err_saturated", 32'(err_count), 32'hFF);

      // Reset pulled while the partial write is still counting wait states.
      sw0 = stack_wr_n;
      @(negedge clk);
      bus.address = 32'h14; bus.read = 1'b0; bus.write = 1'b1;
      bus.writedata = 32'hCAFE_F00D; bus.byteenable = 4'b0011;
      @(posedge clk);
      #1;
      checkOutput("wait_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_readdata", bus.readdata, 32'd0);
      checkOutput("abort_err", 32'(err_count), 32'd0);
      checkOutput("abort_strobes", 32'({stack_read, stack_write, prog_read, prog_write}), 32'd0);
      bus.write = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      err_exp = 0;
      last_read = 32'd0;
      checkOutput("abort_no_write", 32'(stack_wr_n - sw0), 32'd0);
      applyStimulus(32'h0000_0014, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0);

      // Reset landing in the merge write cycle must drop that write.
      sw0 = stack_wr_n;
      @(negedge clk);
      bus.address = 32'h28; bus.read = 1'b0; bus.write = 1'b1;
      bus.writedata = 32'h5566_7788; bus.byteenable = 4'b1100;
      repeat (W + 3) @(posedge clk);
      #1;
      checkOutput("merge_strobe", 32'(stack_write), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("merge_dropped", 32'(stack_write), 32'd0);
      bus.write = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      err_exp = 0;
      last_read = 32'd0;
      checkOutput("merge_no_write", 32'(stack_wr_n - sw0), 32'd0);
      applyStimulus(32'h0000_0028, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0);

      applyStimulus(32'hBFC0_0020, 1'b1, 1'b0, 32'd0, 4'hF, 1'b1);
      applyStimulus(32'h0000_0044, 1'b0, 1'b1, 32'h7788_99AA, 4'b1001, 1'b1);
      applyStimulus(32'h0000_3FFC, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0);
      applyStimulus(32'h0000_4000, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0);
      applyStimulus(PB - 32'd4, 1'b0, 1'b1, 32'h1111_2222, 4'hF, 1'b0);
      applyStimulus(PB + 32'h3FFC, 1'b0, 1'b1, 32'h3333_4444, 4'hF, 1'b0);
      applyStimulus(PB + 32'h3FFC, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0);
      applyStimulus(PB + 32'h4000, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0);

      for (int n = 0; n < 200; n++) begin
         kind = $urandom_range(0, 9);
         rsel = $urandom_range(0, 19);
         wsel = ($urandom_range(0, 9) == 0) ? 4095 : $urandom_range(0, 79);
         if (rsel < 9)       addr = 32'(wsel * 4) + 32'($urandom_range(0, 3));
         else if (rsel < 18) addr = PB + 32'(wsel * 4) + 32'($urandom_range(0, 3));
         else                addr = 32'($urandom_range(32'h4000, 32'hBFBF_FFFF));
         case (kind)
            0, 1, 2, 3: applyStimulus(addr, 1'b1, 1'b0, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
            4, 5:       applyStimulus(addr, 1'b0, 1'b1, $urandom, 4'hF, $urandom_range(0, 3) == 0);
            6, 7:       applyStimulus(addr, 1'b0, 1'b1, $urandom, 4'($urandom_range(1, 14)), $urandom_range(0, 3) == 0);
            8:          applyStimulus(addr, 1'b0, 1'b1, $urandom, 4'h0, 1'b0);
            default:    applyStimulus(addr, 1'b1, 1'b1, $urandom, 4'hF, 1'b0);
         endcase
      end

      for (int i = 0; i < 80; i++) begin
         checkOutput($sformatf("stack_mem[%0d]", i), stack_ram[i], stack_ref[i]);
         checkOutput($sformatf("prog_mem[%0d]", i), prog_ram[i], prog_ref[i]);
      end
      checkOutput("stack_mem[4095]", stack_ram[4095], stack_ref[4095]);
      checkOutput("prog_mem[4095]", prog_ram[4095], prog_ref[4095]);
      checkOutput("single_strobe", 32'(multi_n), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
